// File: rtl/clockworks_pkg.sv
// Shared constants and helpers for the clockworks clock/reset generator.
package clockworks_pkg;

    localparam int SLOW_DEFAULT       = 19;
    localparam int RESET_HOLD_DEFAULT = 4;

    function automatic int hold_w(input int hold);
        return $clog2(hold + 1);
    endfunction

endpackage

// File: rtl/clockworks_reset_stretch.sv
// Stretches RESET into an active-low resetn, counted in wrap strobes.
module clockworks_reset_stretch
    import clockworks_pkg::*;
#(
    parameter int RESET_HOLD = RESET_HOLD_DEFAULT
) (
    input  logic CLK,
    input  logic RESET,
    input  logic wrap,
    output logic resetn
);

    localparam int HW = hold_w(RESET_HOLD);
    localparam logic [HW-1:0] HOLD_INIT = HW'(RESET_HOLD);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

    // Initial values give the held-in-reset state at configuration.
    logic [HW-1:0] hold     = HOLD_INIT;
    logic          resetn_q = 1'b0;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            hold     <= HOLD_INIT;
            resetn_q <= 1'b0;
        end else if (wrap) begin
            if (hold != '0)
                hold <= hold - HOLD_ONE;
            resetn_q <= (hold <= HOLD_ONE);
        end
    end

    assign resetn = resetn_q;

endmodule

// File: rtl/clockworks_gen.sv
// Divided system clock plus stretched reset generator.
// Divider compiled in only with `define CLOCKWORKS_DIVIDER_EN.
module clockworks_gen
    import clockworks_pkg::*;
#(
    parameter int SLOW       = SLOW_DEFAULT,
    parameter int RESET_HOLD = RESET_HOLD_DEFAULT
) (
    input  logic CLK,
    input  logic RESET,
    output logic clk,
    output logic resetn
);

    if (SLOW < 0 || SLOW > 30) begin : g_bad_slow
        $error("clockworks_gen: SLOW out of range");
    end
    if (RESET_HOLD < 1 || RESET_HOLD > 255) begin : g_bad_hold
        $error("clockworks_gen: RESET_HOLD out of range");
    end

    logic wrap;

`ifdef CLOCKWORKS_DIVIDER_EN
    logic [SLOW:0] cnt = '0;

    always_ff @(posedge CLK) begin
        if (RESET)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    // Top bit is a flop output, so clk is glitch-free.
    assign clk  = cnt[SLOW];
    assign wrap = &cnt;
`else
    assign clk  = CLK;
    assign wrap = 1'b1;
`endif

    clockworks_reset_stretch #(
        .RESET_HOLD(RESET_HOLD)
    ) u_stretch (
        .CLK   (CLK),
        .RESET (RESET),
        .wrap  (wrap),
        .resetn(resetn)
    );

endmodule

// File: tb/tb_clockworks_gen.sv
// Directed bench for clockworks_gen with SLOW=2, RESET_HOLD=3.
module tb_clockworks_gen;

`ifdef CLOCKWORKS_DIVIDER_EN
    localparam bit DIV = 1'b1;
`else
    localparam bit DIV = 1'b0;
`endif

    // Divided period 8 CLK, hold 3 periods -> resetn at edge 24.
    // Without divider every edge wraps -> resetn at edge 3.
    localparam int HOLD_EDGES = DIV ? 24 : 3;
    localparam int MID_EDGE   = DIV ? 13 : 2;

    logic CLK = 1'b0;
    logic RESET = 1'b0;
    logic clk;
    logic resetn;

    int n_cmp = 0;
    int n_err = 0;

    clockworks_gen #(
        .SLOW      (2),
        .RESET_HOLD(3)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .clk   (clk),
        .resetn(resetn)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h want %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic exp_clk(input int e);
        if (DIV)
            return ((e % 8) >= 4);
        return 1'b1;
    endfunction

    // n edges after a release, edge 1 = first edge with RESET low
    task automatic run(input string tag, input int n);
        for (int e = 1; e <= n; e++) begin
            @(posedge CLK);
            #1;
            chk({tag, "_clk_r"}, {31'd0, clk}, {31'd0, exp_clk(e)});
            chk({tag, "_rstn"}, {31'd0, resetn},
                {31'd0, (e >= HOLD_EDGES)});
            @(negedge CLK);
            #1;
            chk({tag, "_clk_f"}, {31'd0, clk},
                {31'd0, DIV ? exp_clk(e) : 1'b0});
        end
    endtask

    task automatic hold_reset(input string tag, input int n);
        RESET = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
            chk({tag, "_clk"}, {31'd0, clk}, {31'd0, !DIV});
            chk({tag, "_rstn"}, {31'd0, resetn}, 32'd0);
            @(negedge CLK);
            #1;
        end
        RESET = 1'b0;
    endtask

    initial begin
        #1;
        chk("pwr_clk0", {31'd0, clk}, 32'd0);
        chk("pwr_rstn0", {31'd0, resetn}, 32'd0);
        run("pwr", 30);

        hold_reset("rst5", 5);
        run("rel", 30);
        run("steady", 0);
        for (int e = 31; e <= 46; e++) begin
            @(posedge CLK);
            #1;
            chk("steady_clk", {31'd0, clk}, {31'd0, exp_clk(e)});
            chk("steady_rstn", {31'd0, resetn}, 32'd1);
            @(negedge CLK);
            #1;
        end

        hold_reset("pre_mid", 1);
        run("to_mid", MID_EDGE - 1);
        hold_reset("mid", 1);
        run("after_mid", 30);

        hold_reset("late", 1);
        run("after_late", 30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
